// File: rtl/laser_pkg.sv
// Shared types and constants for the laser placer scoring path.
package laser_pkg;

  localparam int NPTS      = 40;
  localparam int COORD_W   = 4;
  localparam int CNT_W     = 6;
  localparam int RADIUS_SQ = 16;

  localparam logic [CNT_W-1:0]     NPTS_C      = CNT_W'(NPTS);
  localparam logic [CNT_W-1:0]     CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [2*COORD_W:0]   RADIUS_SQ_C = (2*COORD_W+1)'(RADIUS_SQ);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCORE = 2'd1,
    HOLD  = 2'd2
  } score_state_e;

  // Squared euclidean distance; 2*COORD_W+1 bits cannot overflow for 4-bit coordinates.
  function automatic logic [2*COORD_W:0] dist_sq(input point_t a, input point_t b);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2*COORD_W:0] wx;
    logic [2*COORD_W:0] wy;
    dx = (a.x > b.x) ? (a.x - b.x) : (b.x - a.x);
    dy = (a.y > b.y) ? (a.y - b.y) : (b.y - a.y);
    wx = {{(COORD_W+1){1'b0}}, dx};
    wy = {{(COORD_W+1){1'b0}}, dy};
    return (wx * wx) + (wy * wy);
  endfunction

endpackage

// File: rtl/laser_cover_test.sv
// Combinational coverage test: is a point inside either radius-4 circle.
module laser_cover_test
  import laser_pkg::*;
(
  input  point_t pt,
  input  point_t c1,
  input  point_t c2,
  output logic   covered
);

  // Coincident centres simply yield the same test twice
  always_comb begin
    covered = (dist_sq(pt, c1) <= RADIUS_SQ_C) || (dist_sq(pt, c2) <= RADIUS_SQ_C);
  end

endmodule

// File: rtl/laser_cover_scorer.sv
// Snoops a placer frame into ping-pong banks, rescores it against the latched
// centres and offers the covered-point count on a valid/ready port.
module laser_cover_scorer
  import laser_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               PT_VALID,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE_IN,
  output logic [CNT_W-1:0]   SCORE,
  output logic               SCORE_VALID,
  input  logic               SCORE_READY,
  output logic [CNT_W-1:0]   BEST_SCORE,
  output logic               BUSY,
  output logic               ERR_SHORT,
  output logic               OVERRUN
);

  point_t       bank_r [2][NPTS];
  point_t       c1_r, c2_r, rd_pt_s;
  logic         load_sel_r;
  logic [CNT_W-1:0] wr_idx_r, rd_idx_r, acc_r, score_r, best_r;
  logic         score_valid_r, busy_r, err_short_r, overrun_r;
  score_state_e state_r, state_next_s;
  logic         full_s, accept_s, transfer_s, pt_we_s, pt_bank_s, covered_s;
  logic [CNT_W-1:0] pt_idx_s;

  // Frame-boundary decisions and point write addressing
  always_comb begin
    full_s     = (wr_idx_r == NPTS_C);
    accept_s   = DONE_IN && full_s && (state_r == IDLE) && !score_valid_r;
    transfer_s = score_valid_r && SCORE_READY;
    pt_we_s    = PT_VALID && (DONE_IN || !full_s);
    pt_idx_s   = DONE_IN ? CNT_ZERO : wr_idx_r;
    pt_bank_s  = accept_s ? ~load_sel_r : load_sel_r;
    if (rd_idx_r < NPTS_C) begin
      rd_pt_s = bank_r[~load_sel_r][rd_idx_r];
    end else begin
      rd_pt_s = bank_r[~load_sel_r][0];
    end
  end

  laser_cover_test u_cover (
    .pt      (rd_pt_s),
    .c1      (c1_r),
    .c2      (c2_r),
    .covered (covered_s)
  );

  // Point banks: contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (pt_we_s) begin
      bank_r[pt_bank_s][pt_idx_s] <= point_t'({X, Y});
    end
  end

  // Score FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Score FSM next state; the extra rd_idx==NPTS cycle commits the final point
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:             state_next_s = accept_s ? laser_pkg::SCORE : IDLE;
      laser_pkg::SCORE: state_next_s = (rd_idx_r == NPTS_C) ? HOLD : laser_pkg::SCORE;
      HOLD:             state_next_s = SCORE_READY ? IDLE : HOLD;
      default:          state_next_s = IDLE;
    endcase
  end

  // Load pointer, bank swap, accumulator and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_sel_r    <= 1'b0;
      wr_idx_r      <= CNT_ZERO;
      rd_idx_r      <= CNT_ZERO;
      acc_r         <= CNT_ZERO;
      score_r       <= CNT_ZERO;
      best_r        <= CNT_ZERO;
      score_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      err_short_r   <= 1'b0;
      overrun_r     <= 1'b0;
      c1_r          <= '0;
      c2_r          <= '0;
    end else begin
      err_short_r <= DONE_IN && !full_s;
      busy_r      <= (state_next_s == laser_pkg::SCORE);
      if (DONE_IN) begin
        wr_idx_r <= PT_VALID ? CNT_ONE : CNT_ZERO;
      end else if (pt_we_s) begin
        wr_idx_r <= wr_idx_r + CNT_ONE;
      end
      if ((DONE_IN && full_s && !accept_s) || (PT_VALID && !DONE_IN && full_s)) begin
        overrun_r <= 1'b1;
      end
      if (accept_s) begin
        load_sel_r <= ~load_sel_r;
        c1_r       <= point_t'({C1X, C1Y});
        c2_r       <= point_t'({C2X, C2Y});
        rd_idx_r   <= CNT_ZERO;
        acc_r      <= CNT_ZERO;
      end else if ((state_r == laser_pkg::SCORE) && (rd_idx_r < NPTS_C)) begin
        acc_r    <= acc_r + {{(CNT_W-1){1'b0}}, covered_s};
        rd_idx_r <= rd_idx_r + CNT_ONE;
      end
      if ((state_r == laser_pkg::SCORE) && (rd_idx_r == NPTS_C)) begin
        score_r       <= acc_r;
        score_valid_r <= 1'b1;
      end else if (transfer_s) begin
        score_valid_r <= 1'b0;
        if (score_r > best_r) begin
          best_r <= score_r;
        end
      end
    end
  end

  // Ports are driven straight from registers
  always_comb begin
    SCORE       = score_r;
    SCORE_VALID = score_valid_r;
    BEST_SCORE  = best_r;
    BUSY        = busy_r;
    ERR_SHORT   = err_short_r;
    OVERRUN     = overrun_r;
  end

endmodule
